// File: rtl/cell_write_scheduler.sv
// Round-robin scheduler merging two cell-write requesters onto the single
// matrix_display write port, with a once-per-frame commit strobe at vblank start.
module cell_write_scheduler #(
  parameter int S_HEIGHT   = 768,
  parameter int WIDTH      = 20,
  parameter int HEIGHT     = 15,
  parameter int B_S_WIDTH  = 10,
  parameter int B_S_HEIGHT = 10,
  parameter int B_WIDTH    = 5,
  parameter int B_HEIGHT   = 4,
  parameter int B_VGA      = 4
) (
  input  logic                  vclock,
  input  logic                  reset,
  input  logic [B_S_WIDTH-1:0]  hcount,
  input  logic [B_S_HEIGHT-1:0] vcount,
  input  logic                  a_req,
  input  logic [B_WIDTH-1:0]    a_x,
  input  logic [B_HEIGHT-1:0]   a_y,
  input  logic [3*B_VGA-1:0]    a_rgb,
  output logic                  a_ack,
  input  logic                  b_req,
  input  logic [B_WIDTH-1:0]    b_x,
  input  logic [B_HEIGHT-1:0]   b_y,
  input  logic [3*B_VGA-1:0]    b_rgb,
  output logic                  b_ack,
  output logic [B_WIDTH-1:0]    cell_x,
  output logic [B_HEIGHT-1:0]   cell_y,
  output logic [3*B_VGA-1:0]    cell_rgb,
  output logic                  cell_en,
  output logic                  update,
  output logic                  range_err
);

  typedef enum logic [1:0] {ACCEPT, COMMIT, BLANK} state_t;

  localparam logic [B_S_HEIGHT-1:0] VBLANK_LINE = B_S_HEIGHT'(S_HEIGHT);
  localparam logic [B_WIDTH-1:0]    X_LIMIT     = B_WIDTH'(WIDTH);
  localparam logic [B_HEIGHT-1:0]   Y_LIMIT     = B_HEIGHT'(HEIGHT);

  state_t                state, state_n;
  logic                  dirty, dirty_n;
  logic                  rr_last, rr_last_n;   // 1: port B was granted last
  logic                  a_ack_n, b_ack_n, cell_en_n, update_n, range_err_n;
  logic [B_WIDTH-1:0]    cell_x_n;
  logic [B_HEIGHT-1:0]   cell_y_n;
  logic [3*B_VGA-1:0]    cell_rgb_n;

  logic                  vblank_start, frame_start, grant_ok;
  logic                  a_ok, b_ok, pick_a, pick_b;
  logic [B_WIDTH-1:0]    g_x;
  logic [B_HEIGHT-1:0]   g_y;
  logic [3*B_VGA-1:0]    g_rgb;

  assign vblank_start = (vcount == VBLANK_LINE) && (hcount == '0);
  assign frame_start  = (vcount == '0) && (hcount == '0);

  // NOTE: every signal assigned below gets a default first, so no path leaves one unassigned (no latches).
  always_comb begin
    state_n     = state;
    dirty_n     = dirty;
    rr_last_n   = rr_last;
    a_ack_n     = 1'b0;
    b_ack_n     = 1'b0;
    cell_en_n   = 1'b0;
    update_n    = 1'b0;
    range_err_n = range_err;
    cell_x_n    = cell_x;
    cell_y_n    = cell_y;
    cell_rgb_n  = cell_rgb;
    grant_ok    = 1'b0;

    case (state)
      ACCEPT: begin
        if (vblank_start) begin
          if (dirty) begin
            state_n  = COMMIT;
            update_n = 1'b1;
          end else begin
            state_n  = BLANK;
          end
        end else begin
          grant_ok = 1'b1;
        end
      end
      COMMIT: begin
        dirty_n = 1'b0;
        state_n = BLANK;
      end
      BLANK: begin
        grant_ok = 1'b1;
        if (frame_start) state_n = ACCEPT;
      end
      default: state_n = ACCEPT;
    endcase

    // A port acked last cycle sits out one cycle so a late-dropped req is not written twice.
    a_ok   = grant_ok && a_req && !a_ack;
    b_ok   = grant_ok && b_req && !b_ack;
    pick_a = a_ok && (!b_ok || rr_last);
    pick_b = b_ok && !pick_a;

    g_x   = pick_a ? a_x   : b_x;
    g_y   = pick_a ? a_y   : b_y;
    g_rgb = pick_a ? a_rgb : b_rgb;

    if (pick_a || pick_b) begin
      a_ack_n   = pick_a;
      b_ack_n   = pick_b;
      rr_last_n = pick_b;
      if ((g_x < X_LIMIT) && (g_y < Y_LIMIT)) begin
        cell_en_n  = 1'b1;
        cell_x_n   = g_x;
        cell_y_n   = g_y;
        cell_rgb_n = g_rgb;
        dirty_n    = 1'b1;
      end else begin
        range_err_n = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge vclock or posedge reset) begin
    if (reset) begin
      state     <= ACCEPT;
      dirty     <= 1'b0;
      rr_last   <= 1'b1;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      cell_en   <= 1'b0;
      update    <= 1'b0;
      range_err <= 1'b0;
      cell_x    <= '0;
      cell_y    <= '0;
      cell_rgb  <= '0;
    end else begin
      state     <= state_n;
      dirty     <= dirty_n;
      rr_last   <= rr_last_n;
      a_ack     <= a_ack_n;
      b_ack     <= b_ack_n;
      cell_en   <= cell_en_n;
      update    <= update_n;
      range_err <= range_err_n;
      cell_x    <= cell_x_n;
      cell_y    <= cell_y_n;
      cell_rgb  <= cell_rgb_n;
    end
  end

endmodule

// File: tb/tb_cell_write_scheduler.sv
// Table-driven bench for cell_write_scheduler: a directed vector table walks
// arbitration, range drops and frame commits; a hand sequence covers async reset.
module tb_cell_write_scheduler;

  localparam logic [1:0] P_N = 2'd0;  // mid-frame raster position
  localparam logic [1:0] P_V = 2'd1;  // vblank start (768,0)
  localparam logic [1:0] P_F = 2'd2;  // frame start (0,0)

  logic        vclock = 1'b0;
  logic        reset  = 1'b1;
  logic [9:0]  hcount = '0;
  logic [9:0]  vcount = '0;
  logic        a_req = 1'b0, b_req = 1'b0;
  logic [4:0]  a_x = '0, b_x = '0;
  logic [3:0]  a_y = '0, b_y = '0;
  logic [11:0] a_rgb = '0, b_rgb = '0;
  logic        a_ack, b_ack, cell_en, update, range_err;
  logic [4:0]  cell_x;
  logic [3:0]  cell_y;
  logic [11:0] cell_rgb;

  int n_pass  = 0;
  int n_total = 0;

  always #5 vclock = ~vclock;

  cell_write_scheduler dut (
    .vclock(vclock), .reset(reset), .hcount(hcount), .vcount(vcount),
    .a_req(a_req), .a_x(a_x), .a_y(a_y), .a_rgb(a_rgb), .a_ack(a_ack),
    .b_req(b_req), .b_x(b_x), .b_y(b_y), .b_rgb(b_rgb), .b_ack(b_ack),
    .cell_x(cell_x), .cell_y(cell_y), .cell_rgb(cell_rgb),
    .cell_en(cell_en), .update(update), .range_err(range_err)
  );

  // Output snapshot: {a_ack, b_ack, cell_en, update, range_err, cell_x, cell_y, cell_rgb}
  function automatic logic [25:0] snap();
    return {a_ack, b_ack, cell_en, update, range_err, cell_x, cell_y, cell_rgb};
  endfunction

  typedef struct {
    logic [1:0]  pos;
    logic        ar;
    logic [4:0]  ax;
    logic [3:0]  ay;
    logic [11:0] argb;
    logic        br;
    logic [4:0]  bx;
    logic [3:0]  by;
    logic [11:0] brgb;
    logic [25:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [1:0] pos,
                     input logic ar, input logic [4:0] ax, input logic [3:0] ay, input logic [11:0] argb,
                     input logic br, input logic [4:0] bx, input logic [3:0] by, input logic [11:0] brgb,
                     input logic ea, input logic eb, input logic en, input logic eu, input logic er,
                     input logic [4:0] ex, input logic [3:0] ey, input logic [11:0] ergb);
    vec_t v;
    v.pos = pos; v.ar = ar; v.ax = ax; v.ay = ay; v.argb = argb;
    v.br = br; v.bx = bx; v.by = by; v.brgb = brgb;
    v.exp = {ea, eb, en, eu, er, ex, ey, ergb};
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [25:0] act, input logic [25:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %h (ack_a,ack_b,en,upd,err,x,y,rgb) required %h", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic set_pos(input logic [1:0] pos);
    case (pos)
      P_V:     begin vcount = 10'd768; hcount = 10'd0; end
      P_F:     begin vcount = 10'd0;   hcount = 10'd0; end
      default: begin vcount = 10'd100; hcount = 10'd5; end
    endcase
  endtask

  task automatic tick();
    @(posedge vclock);
    #1;
  endtask

  initial begin
    // Both ports held for 8 cycles: strict A,B alternation starting with A.
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0)
        add(P_N, 1, 5'd1, 4'd2, 12'h0A1, 1, 5'd5, 4'd6, 12'h0B2, 1, 0, 1, 0, 0, 5'd1, 4'd2, 12'h0A1);
      else
        add(P_N, 1, 5'd1, 4'd2, 12'h0A1, 1, 5'd5, 4'd6, 12'h0B2, 0, 1, 1, 0, 0, 5'd5, 4'd6, 12'h0B2);
    end
    add(P_N, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd5, 4'd6, 12'h0B2);
    add(P_V, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'd5, 4'd6, 12'h0B2);
    add(P_N, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd5, 4'd6, 12'h0B2);
    add(P_F, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd5, 4'd6, 12'h0B2);
    // Single A write, then commit at vblank start.
    add(P_N, 1, 5'd3, 4'd4, 12'hF00, 0, 0, 0, 0, 1, 0, 1, 0, 0, 5'd3, 4'd4, 12'hF00);
    add(P_N, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd3, 4'd4, 12'hF00);
    add(P_V, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'd3, 4'd4, 12'hF00);
    add(P_N, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd3, 4'd4, 12'hF00);
    add(P_F, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd3, 4'd4, 12'hF00);
    // Clean frame: no commit.
    add(P_V, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd3, 4'd4, 12'hF00);
    add(P_F, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd3, 4'd4, 12'hF00);
    // B at x=WIDTH: acked, dropped, sticky error, no commit.
    add(P_N, 0, 0, 0, 0, 1, 5'd20, 4'd1, 12'h123, 0, 1, 0, 0, 1, 5'd3, 4'd4, 12'hF00);
    add(P_N, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd3, 4'd4, 12'hF00);
    add(P_V, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd3, 4'd4, 12'hF00);
    add(P_F, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd3, 4'd4, 12'hF00);
    // y=HEIGHT dropped; corner (19,14) accepted.
    add(P_N, 1, 5'd19, 4'd15, 12'h456, 0, 0, 0, 0, 1, 0, 0, 0, 1, 5'd3, 4'd4, 12'hF00);
    add(P_N, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd3, 4'd4, 12'hF00);
    add(P_N, 1, 5'd19, 4'd14, 12'h0FF, 0, 0, 0, 0, 1, 0, 1, 0, 1, 5'd19, 4'd14, 12'h0FF);
    add(P_N, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd19, 4'd14, 12'h0FF);
    // Request in the vblank-start cycle: commit first, no grant in COMMIT, granted in BLANK.
    add(P_V, 1, 5'd7, 4'd8, 12'hABC, 0, 0, 0, 0, 0, 0, 0, 1, 1, 5'd19, 4'd14, 12'h0FF);
    add(P_N, 1, 5'd7, 4'd8, 12'hABC, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd19, 4'd14, 12'h0FF);
    add(P_N, 1, 5'd7, 4'd8, 12'hABC, 0, 0, 0, 0, 1, 0, 1, 0, 1, 5'd7, 4'd8, 12'hABC);
    add(P_N, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd7, 4'd8, 12'hABC);
    add(P_F, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd7, 4'd8, 12'hABC);
    add(P_V, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 5'd7, 4'd8, 12'hABC);
    add(P_N, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd7, 4'd8, 12'hABC);
    add(P_F, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd7, 4'd8, 12'hABC);

    set_pos(P_N);
    tick();
    tick();
    check("reset_state", snap(), 26'd0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      set_pos(vecs[i].pos);
      a_req = vecs[i].ar; a_x = vecs[i].ax; a_y = vecs[i].ay; a_rgb = vecs[i].argb;
      b_req = vecs[i].br; b_x = vecs[i].bx; b_y = vecs[i].by; b_rgb = vecs[i].brgb;
      tick();
      check($sformatf("vec%0d", i), snap(), vecs[i].exp);
    end

    // Async reset with a pending request and dirty set.
    set_pos(P_N);
    a_req = 1'b1; a_x = 5'd1; a_y = 4'd1; a_rgb = 12'h111;
    tick();
    check("pre_reset_write", snap(), {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 5'd1, 4'd1, 12'h111});
    a_x = 5'd2; a_y = 4'd2; a_rgb = 12'h222;
    #2 reset = 1'b1;
    #1 check("async_reset", snap(), 26'd0);
    tick();
    reset = 1'b0;
    a_req = 1'b0;
    set_pos(P_V);
    tick();
    check("no_update_after_reset", snap(), 26'd0);
    set_pos(P_F);
    tick();
    set_pos(P_N);
    a_req = 1'b1;
    tick();
    check("rerequest_write", snap(), {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5'd2, 4'd2, 12'h222});
    a_req = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
